// File: rtl/arm_pkg.sv
// Shared definitions for the ARM pipeline control slice: SRAM FSM encoding
// and default widths/latencies.
package arm_pkg;

  localparam int DEF_REG_W     = 4;
  localparam int DEF_SRAM_WAIT = 5;
  localparam int WAIT_CNT_W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } sram_state_t;

endpackage

// File: rtl/pipeline_controller_hazard_detect.sv
// RAW hazard equation between ID sources and EXE/MEM destinations.
// With forwarding only a load in EXE can still force a stall.
module hazard_detect
  import arm_pkg::*;
#(
  parameter int REG_W = DEF_REG_W
) (
  input  logic             fwd_en,
  input  logic             id_use_src1,
  input  logic             id_two_src,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wb_en,
  output logic             hazard
);

  logic match_exe;
  logic match_mem;

  assign match_exe = (id_use_src1 && (id_src1 == exe_dest)) ||
                     (id_two_src  && (id_src2 == exe_dest));
  assign match_mem = (id_use_src1 && (id_src1 == mem_dest)) ||
                     (id_two_src  && (id_src2 == mem_dest));

  always_comb begin
    if (fwd_en) begin
      hazard = exe_mem_r_en && match_exe;
    end else begin
      hazard = (exe_wb_en && match_exe) || (mem_wb_en && match_mem);
    end
  end

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline sequencing: SRAM wait-state freeze, branch flush, hazard stall
// (in that priority) plus saturating event counters.
module pipeline_controller
  import arm_pkg::*;
#(
  parameter int SRAM_WAIT = DEF_SRAM_WAIT,
  parameter int REG_W     = DEF_REG_W,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fwd_en,
  input  logic             id_use_src1,
  input  logic             id_two_src,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic             exe_b_taken,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wb_en,
  input  logic             mem_r_en,
  input  logic             mem_w_en,
  output logic             sram_req,
  output logic             mem_done,
  output logic             freeze_all,
  output logic             stall_front,
  output logic             bubble_id_exe,
  output logic             flush_if_id,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] mem_wait_cnt
);

  sram_state_t           state_reg, state_next;
  logic [WAIT_CNT_W-1:0] wait_reg, wait_next;
  logic                  mem_access;
  logic                  freeze_raw;
  logic                  done_raw;
  logic                  hazard;

  assign mem_access = mem_r_en || mem_w_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      wait_reg  <= '0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
    end
  end

  // The first freeze cycle is spent in IDLE, so WAIT covers SRAM_WAIT-1 cycles.
  always_comb begin
    state_next = state_reg;
    wait_next  = wait_reg;
    case (state_reg)
      IDLE: begin
        if (mem_access) begin
          wait_next  = WAIT_CNT_W'(SRAM_WAIT - 1);
          state_next = (SRAM_WAIT == 1) ? DONE : WAIT;
        end
      end
      WAIT: begin
        wait_next = wait_reg - 1'b1;
        if (wait_reg == 4'd1) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    freeze_raw = 1'b0;
    done_raw   = 1'b0;
    case (state_reg)
      IDLE:    freeze_raw = mem_access;
      WAIT:    freeze_raw = 1'b1;
      DONE:    done_raw   = 1'b1;
      default: freeze_raw = 1'b0;
    endcase
  end

  hazard_detect #(.REG_W(REG_W)) u_hazard (
    .fwd_en       (fwd_en),
    .id_use_src1  (id_use_src1),
    .id_two_src   (id_two_src),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .exe_dest     (exe_dest),
    .exe_wb_en    (exe_wb_en),
    .exe_mem_r_en (exe_mem_r_en),
    .mem_dest     (mem_dest),
    .mem_wb_en    (mem_wb_en),
    .hazard       (hazard)
  );

  // Outputs are forced low while reset is asserted, independent of inputs.
  assign freeze_all    = !rst && freeze_raw;
  assign sram_req      = freeze_all;
  assign mem_done      = !rst && done_raw;
  assign flush_if_id   = !rst && !freeze_raw && exe_b_taken;
  assign stall_front   = !rst && !freeze_raw && !exe_b_taken && hazard;
  assign bubble_id_exe = !rst && !freeze_raw && (exe_b_taken || hazard);

  logic [2:0]       evt;
  logic [CNT_W-1:0] cnt_reg [3];

  assign evt = {freeze_all, flush_if_id, stall_front};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_reg[gi] <= '0;
        end else if (evt[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
          cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
        end
      end
    end
  endgenerate

  assign stall_cnt    = cnt_reg[0];
  assign flush_cnt    = cnt_reg[1];
  assign mem_wait_cnt = cnt_reg[2];

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller; counters use a 4-bit width so
// saturation at 15 is reachable.
module tb_pipeline_controller;

  localparam int REG_W = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             fwd_en = 1'b0;
  logic             id_use_src1 = 1'b0;
  logic             id_two_src = 1'b0;
  logic [REG_W-1:0] id_src1 = '0;
  logic [REG_W-1:0] id_src2 = '0;
  logic [REG_W-1:0] exe_dest = '0;
  logic             exe_wb_en = 1'b0;
  logic             exe_mem_r_en = 1'b0;
  logic             exe_b_taken = 1'b0;
  logic [REG_W-1:0] mem_dest = '0;
  logic             mem_wb_en = 1'b0;
  logic             mem_r_en = 1'b0;
  logic             mem_w_en = 1'b0;
  logic             sram_req, mem_done, freeze_all, stall_front;
  logic             bubble_id_exe, flush_if_id;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, mem_wait_cnt;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  pipeline_controller #(.SRAM_WAIT(5), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk (clk), .rst (rst), .fwd_en (fwd_en),
    .id_use_src1 (id_use_src1), .id_two_src (id_two_src),
    .id_src1 (id_src1), .id_src2 (id_src2),
    .exe_dest (exe_dest), .exe_wb_en (exe_wb_en),
    .exe_mem_r_en (exe_mem_r_en), .exe_b_taken (exe_b_taken),
    .mem_dest (mem_dest), .mem_wb_en (mem_wb_en),
    .mem_r_en (mem_r_en), .mem_w_en (mem_w_en),
    .sram_req (sram_req), .mem_done (mem_done), .freeze_all (freeze_all),
    .stall_front (stall_front), .bubble_id_exe (bubble_id_exe),
    .flush_if_id (flush_if_id), .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt), .mem_wait_cnt (mem_wait_cnt)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_ctrl(input string tag, input logic st, input logic bb, input logic fl);
    chk({tag, ".stall"}, 16'(stall_front), 16'(st));
    chk({tag, ".bubble"}, 16'(bubble_id_exe), 16'(bb));
    chk({tag, ".flush"}, 16'(flush_if_id), 16'(fl));
  endtask

  task automatic clear_inputs();
    fwd_en = 0; id_use_src1 = 0; id_two_src = 0; id_src1 = 0; id_src2 = 0;
    exe_dest = 0; exe_wb_en = 0; exe_mem_r_en = 0; exe_b_taken = 0;
    mem_dest = 0; mem_wb_en = 0; mem_r_en = 0; mem_w_en = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Five freeze cycles then one mem_done cycle; returns at the negedge after DONE.
  task automatic freeze_window(input string tag);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk({tag, ".freeze"}, 16'(freeze_all), 16'd1);
      chk({tag, ".sram_req"}, 16'(sram_req), 16'd1);
      chk({tag, ".done_low"}, 16'(mem_done), 16'd0);
      @(negedge clk);
    end
    #1;
    chk({tag, ".freeze_off"}, 16'(freeze_all), 16'd0);
    chk({tag, ".mem_done"}, 16'(mem_done), 16'd1);
    @(negedge clk);
  endtask

  initial begin
    // Reset: outputs low even with a memory op presented.
    mem_r_en = 1'b1; exe_b_taken = 1'b1;
    #2;
    chk("rst.freeze", 16'(freeze_all), 16'd0);
    chk("rst.sram_req", 16'(sram_req), 16'd0);
    chk("rst.flush", 16'(flush_if_id), 16'd0);
    chk("rst.mem_wait_cnt", 16'(mem_wait_cnt), 16'd0);
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;

    $display("step: LDR in MEM, SRAM_WAIT=5");
    mem_r_en = 1'b1;
    freeze_window("ldr");
    mem_r_en = 1'b0;
    #1;
    chk("ldr.after_done", 16'(mem_done), 16'd0);
    chk("ldr.after_freeze", 16'(freeze_all), 16'd0);
    chk("ldr.mem_wait_cnt", 16'(mem_wait_cnt), 16'd5);

    $display("step: reset then two back-to-back STRs");
    do_reset();
    #1;
    chk("rst2.mem_wait_cnt", 16'(mem_wait_cnt), 16'd0);
    @(negedge clk);
    mem_w_en = 1'b1;
    freeze_window("str1");
    freeze_window("str2");
    mem_w_en = 1'b0;
    #1;
    chk("str.idle", 16'(freeze_all), 16'd0);
    chk("str.mem_wait_cnt", 16'(mem_wait_cnt), 16'd10);

    $display("step: fwd_en=0 EXE RAW hazard on r3");
    @(negedge clk);
    exe_dest = 3; exe_wb_en = 1; id_src1 = 3; id_use_src1 = 1;
    #1;
    chk_ctrl("raw_exe", 1, 1, 0);
    @(negedge clk);
    id_use_src1 = 0;
    #1;
    chk_ctrl("raw_exe_unused", 0, 0, 0);
    chk("raw_exe.stall_cnt", 16'(stall_cnt), 16'd1);

    $display("step: fwd_en=0 MEM RAW hazard via second source");
    clear_inputs();
    mem_dest = 5; mem_wb_en = 1; id_two_src = 1; id_src2 = 5;
    #1;
    chk_ctrl("raw_mem", 1, 1, 0);
    @(negedge clk);
    fwd_en = 1;
    #1;
    chk_ctrl("fwd_mem_no_stall", 0, 0, 0);
    chk("raw_mem.stall_cnt", 16'(stall_cnt), 16'd2);

    $display("step: fwd_en=1 ALU result then load-use");
    clear_inputs();
    fwd_en = 1; exe_dest = 3; exe_wb_en = 1; id_src1 = 3; id_use_src1 = 1;
    #1;
    chk_ctrl("fwd_add", 0, 0, 0);
    @(negedge clk);
    exe_mem_r_en = 1;
    #1;
    chk_ctrl("fwd_ldr", 1, 1, 0);
    @(negedge clk);
    exe_mem_r_en = 0;
    #1;
    chk_ctrl("fwd_ldr_gone", 0, 0, 0);
    chk("fwd_ldr.stall_cnt", 16'(stall_cnt), 16'd3);

    $display("step: branch taken with load-use hazard");
    exe_mem_r_en = 1; exe_b_taken = 1;
    #1;
    chk_ctrl("br_haz", 0, 1, 1);
    @(negedge clk);
    clear_inputs();
    #1;
    chk("br_haz.flush_cnt", 16'(flush_cnt), 16'd1);
    chk("br_haz.stall_cnt", 16'(stall_cnt), 16'd3);

    $display("step: branch taken during SRAM freeze");
    mem_r_en = 1; exe_b_taken = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("br_frz.freeze", 16'(freeze_all), 16'd1);
      chk_ctrl("br_frz", 0, 0, 0);
      @(negedge clk);
    end
    #1;
    chk("br_frz.mem_done", 16'(mem_done), 16'd1);
    chk_ctrl("br_frz_done", 0, 1, 1);
    @(negedge clk);
    clear_inputs();
    #1;
    chk("br_frz.flush_cnt", 16'(flush_cnt), 16'd2);
    chk("br_frz.mem_wait_cnt", 16'(mem_wait_cnt), 16'd15);

    $display("step: extra LDR with mem_wait_cnt saturated");
    mem_r_en = 1;
    freeze_window("sat");
    mem_r_en = 0;
    #1;
    chk("sat.mem_wait_cnt", 16'(mem_wait_cnt), 16'd15);

    $display("step: reset pulse during WAIT");
    @(negedge clk);
    mem_r_en = 1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("abort.pre_freeze", 16'(freeze_all), 16'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("abort.freeze", 16'(freeze_all), 16'd0);
    chk("abort.sram_req", 16'(sram_req), 16'd0);
    chk("abort.mem_wait_cnt", 16'(mem_wait_cnt), 16'd0);
    chk("abort.flush_cnt", 16'(flush_cnt), 16'd0);
    chk("abort.stall_cnt", 16'(stall_cnt), 16'd0);
    @(negedge clk);
    mem_r_en = 0;
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      #1;
      chk("abort.no_done", 16'(mem_done), 16'd0);
      chk("abort.no_freeze", 16'(freeze_all), 16'd0);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
